// File: rtl/seg_hex_capture_if.sv
// Bus between a seven-segment readback source and seg_hex_capture:
// the multiplexed display lines in, one decoded frame out via valid/ready.
interface seg_hex_capture_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    i_sample_en;
  logic [NUM_DIGITS-1:0]   i_digit_sel;
  logic [6:0]              i_seg;
  logic                    o_valid;
  logic                    i_ready;
  logic [4*NUM_DIGITS-1:0] o_value;
  logic [NUM_DIGITS-1:0]   o_error;

  modport master (
    output i_sample_en, i_digit_sel, i_seg, i_ready,
    input  o_valid, o_value, o_error
  );

  modport slave (
    input  i_sample_en, i_digit_sel, i_seg, i_ready,
    output o_valid, o_value, o_error
  );
endinterface

// File: rtl/seg_hex_capture.sv
// Reconstructs the hex value on a multiplexed active-low 7-segment bus and
// emits whole frames over valid/ready. Define SEGCAP_DASH_OK_EN to accept '-'.
module seg_hex_capture #(
  parameter int NUM_DIGITS = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  seg_hex_capture_if.slave bus
);

  localparam logic [3:0] STC = 4'(STABLE_CNT);

  typedef enum logic {COLLECT, PENDING} state_e;

  // Returns {illegal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1000000: return 5'h00;
      7'b1111001: return 5'h01;
      7'b0100100: return 5'h02;
      7'b0110000: return 5'h03;
      7'b0011001: return 5'h04;
      7'b0010010: return 5'h05;
      7'b0000010: return 5'h06;
      7'b1111000: return 5'h07;
      7'b0000000: return 5'h08;
      7'b0010000: return 5'h09;
      7'b0100000: return 5'h0A;
      7'b0000011: return 5'h0B;
      7'b1000110: return 5'h0C;
      7'b0100001: return 5'h0D;
      7'b0000110: return 5'h0E;
      7'b0001110: return 5'h0F;
`ifdef SEGCAP_DASH_OK_EN
      7'b0111111: return 5'h00;
`else
`endif
      default:    return 5'h10;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   last_sel_q, last_sel_d;
  logic [6:0]              last_seg_q, last_seg_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] acc_q, acc_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    o_valid_q, o_valid_d;
  logic [4*NUM_DIGITS-1:0] o_value_q, o_value_d;
  logic [NUM_DIGITS-1:0]   o_error_q, o_error_d;

  logic                    commit;
  logic                    xfer;
  logic [4:0]              dec;
  logic [NUM_DIGITS-1:0]   seen_set;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    last_sel_d = last_sel_q;
    last_seg_d = last_seg_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_d      = err_q;
    seen_d     = seen_q;
    o_valid_d  = o_valid_q;
    o_value_d  = o_value_q;
    o_error_d  = o_error_q;
    commit     = 1'b0;
    dec        = decode(bus.i_seg);

    if (bus.i_sample_en) begin
      if (!$onehot(bus.i_digit_sel)) begin
        cnt_d = '0;
      end else if (bus.i_digit_sel == last_sel_q && bus.i_seg == last_seg_q) begin
        if (cnt_q != STC) begin
          cnt_d  = cnt_q + 4'd1;
          commit = (cnt_d == STC);
        end else begin
          commit = (STABLE_CNT == 1);  // saturated runs only re-commit when one sample suffices
        end
      end else begin
        last_sel_d = bus.i_digit_sel;
        last_seg_d = bus.i_seg;
        cnt_d      = 4'd1;
        commit     = (STABLE_CNT == 1);
      end
    end

    seen_set = commit ? bus.i_digit_sel : '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (seen_set[d]) begin
        acc_d[4*d +: 4] = dec[3:0];
        err_d[d]        = dec[4];
      end
    end

    // The transfer snapshots the pre-commit accumulator; a same-cycle commit opens the next frame.
    xfer = (state_q == PENDING) && (!o_valid_q || bus.i_ready);
    if (o_valid_q && bus.i_ready) o_valid_d = 1'b0;
    if (xfer) begin
      o_valid_d = 1'b1;
      o_value_d = acc_q;
      o_error_d = err_q;
      seen_d    = seen_set;
      state_d   = COLLECT;
    end else begin
      seen_d = seen_q | seen_set;
      if (state_q == COLLECT && &seen_d) state_d = PENDING;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= COLLECT;
      last_sel_q <= '0;
      last_seg_q <= 7'h7F;
      cnt_q      <= '0;
      acc_q      <= '0;
      err_q      <= '0;
      seen_q     <= '0;
      o_valid_q  <= 1'b0;
      o_value_q  <= '0;
      o_error_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_sel_q <= last_sel_d;
      last_seg_q <= last_seg_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
      seen_q     <= seen_d;
      o_valid_q  <= o_valid_d;
      o_value_q  <= o_value_d;
      o_error_q  <= o_error_d;
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_value = o_value_q;
  assign bus.o_error = o_error_q;

endmodule

// File: tb/tb_seg_hex_capture.sv
// Directed plus randomized bench for seg_hex_capture, checked every cycle
// against a sample-run / frame-snapshot reference model.
module tb_seg_hex_capture;

  localparam int ND = 8;
  localparam int SC = 4;
  localparam logic [6:0] PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0100000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_hex_capture_if #(.NUM_DIGITS(ND)) bus ();

  seg_hex_capture #(.NUM_DIGITS(ND), .STABLE_CNT(SC)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: length of the current run of identical one-hot samples,
  // per-digit latest committed values, and the frame/output slot.
  logic [ND-1:0] r_sel;
  logic [6:0]    r_seg;
  int            run;
  logic [3:0]    m_nib [ND];
  logic          m_ill [ND];
  logic [ND-1:0] m_seen;
  bit            m_pend;
  logic          m_valid;
  logic [31:0]   m_value;
  logic [7:0]    m_error;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void decode_ref(input logic [6:0] s, output logic [3:0] n, output logic il);
    n  = 4'h0;
    il = 1'b1;
    for (int i = 0; i < 16; i++) if (PAT[i] == s) begin n = 4'(i); il = 1'b0; end
`ifdef SEGCAP_DASH_OK_EN
    if (s == DASH) il = 1'b0;
`else
`endif
  endfunction

  task automatic model_reset();
    r_sel = '0; r_seg = 7'h7F; run = 0;
    for (int d = 0; d < ND; d++) begin m_nib[d] = 4'h0; m_ill[d] = 1'b0; end
    m_seen = '0; m_pend = 1'b0; m_valid = 1'b0; m_value = '0; m_error = '0;
  endtask

  task automatic model_step(input logic en, input logic [ND-1:0] sel, input logic [6:0] seg,
                            input logic rdy);
    bit commit;
    bit xfer;
    logic [3:0] n;
    logic il;
    if (!rst_n) begin model_reset(); return; end
    commit = 0;
    if (en) begin
      if ($countones(sel) != 1) run = 0;
      else if (sel == r_sel && seg == r_seg) begin run++; commit = (run == SC) || (SC == 1); end
      else begin r_sel = sel; r_seg = seg; run = 1; commit = (SC == 1); end
    end
    xfer = m_pend && (!m_valid || rdy);
    if (m_valid && rdy) m_valid = 1'b0;
    if (xfer) begin
      m_valid = 1'b1;
      for (int d = 0; d < ND; d++) begin m_value[4*d +: 4] = m_nib[d]; m_error[d] = m_ill[d]; end
    end
    if (commit) begin
      decode_ref(seg, n, il);
      for (int d = 0; d < ND; d++) if (sel[d]) begin m_nib[d] = n; m_ill[d] = il; end
    end
    if (xfer) begin
      m_seen = commit ? sel : '0;
      m_pend = 1'b0;
    end else begin
      if (commit) m_seen = m_seen | sel;
      if (m_seen == '1) m_pend = 1'b1;
    end
  endtask

  task automatic cyc(input logic en, input logic [ND-1:0] sel, input logic [6:0] seg, input logic rdy);
    @(negedge clk);
    bus.i_sample_en = en;
    bus.i_digit_sel = sel;
    bus.i_seg       = seg;
    bus.i_ready     = rdy;
    model_step(en, sel, seg, rdy);
    @(posedge clk);
    #1;
    check("valid", 32'(bus.o_valid), 32'(m_valid));
    check("value", bus.o_value, m_value);
    check("error", 32'(bus.o_error), 32'(m_error));
  endtask

  task automatic idle(input logic rdy);
    cyc(1'b0, '0, 7'h7F, rdy);
  endtask

  task automatic show(input int d, input logic [6:0] seg, input int n, input logic rdy);
    logic [ND-1:0] one;
    one = ND'(1) << d;
    repeat (n) cyc(1'b1, one, seg, rdy);
  endtask

  initial begin
    logic [7:0] dash_err;
    logic [ND-1:0] sel;
    logic [6:0] seg;
    int n, r;

    model_reset();
    rst_n = 1'b0;
    bus.i_sample_en = 1'b0; bus.i_digit_sel = '0; bus.i_seg = 7'h7F; bus.i_ready = 1'b0;
    idle(1'b0); idle(1'b0);
    rst_n = 1'b1;
    check("rst_valid", 32'(bus.o_valid), 32'h0);
    check("rst_value", bus.o_value, 32'h0);
    check("rst_error", 32'(bus.o_error), 32'h0);

    // Each digit shows its own index; frame appears one cycle after completion.
    for (int d = 0; d < ND; d++) show(d, PAT[d], SC, 1'b1);
    check("t1_wait", 32'(bus.o_valid), 32'h0);
    idle(1'b1);
    check("t1_valid", 32'(bus.o_valid), 32'h1);
    check("t1_value", bus.o_value, 32'h76543210);
    check("t1_error", 32'(bus.o_error), 32'h0);
    idle(1'b1);
    check("t1_once", 32'(bus.o_valid), 32'h0);

    // Non-one-hot select never commits; a toggling digit commits only once stable.
    repeat (6) cyc(1'b1, 8'b0000_0011, PAT[5], 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'b0000_0100, (i % 2 == 0) ? PAT[2] : PAT[3], 1'b1);
    show(2, PAT[3], SC, 1'b1);
    for (int d = 0; d < ND; d++) if (d != 2) show(d, PAT[10], SC, 1'b1);
    idle(1'b1);
    check("t2_value", bus.o_value, 32'hAAAAA3AA);
    idle(1'b1);

    // Back-pressure: output frozen while a re-commit builds the next frame.
    for (int d = 0; d < ND; d++) show(d, PAT[(d + 1) % 16], SC, 1'b0);
    idle(1'b0);
    repeat (20) idle(1'b0);
    check("t4_hold_v", 32'(bus.o_valid), 32'h1);
    check("t4_hold", bus.o_value, 32'h87654321);
    show(0, PAT[15], SC, 1'b0);
    for (int d = 1; d < ND; d++) show(d, PAT[(d + 1) % 16], SC, 1'b0);
    idle(1'b0);
    check("t4_frozen", bus.o_value, 32'h87654321);
    idle(1'b1);
    check("t4_b2b_v", 32'(bus.o_valid), 32'h1);
    check("t4_next", bus.o_value, 32'h8765432F);
    idle(1'b1);

    // Dash on digit 5.
`ifdef SEGCAP_DASH_OK_EN
    dash_err = 8'h00;
`else
    dash_err = 8'h20;
`endif
    for (int d = 0; d < ND; d++) show(d, (d == 5) ? DASH : PAT[d], SC, 1'b1);
    idle(1'b1);
    check("t5_value", bus.o_value, 32'h76043210);
    check("t5_error", 32'(bus.o_error), 32'(dash_err));
    idle(1'b1);

    // Blank is illegal in every build.
    for (int d = 0; d < ND; d++) show(d, (d == 7) ? BLANK : PAT[1], SC, 1'b1);
    idle(1'b1);
    check("blank_err", 32'(bus.o_error), 32'h80);
    idle(1'b1);

    // Reset with a held frame and a partial frame discards both.
    for (int d = 0; d < ND; d++) show(d, PAT[9], SC, 1'b0);
    idle(1'b0);
    for (int d = 0; d < 5; d++) show(d, PAT[d], SC, 1'b0);
    rst_n = 1'b0;
    idle(1'b0);
    rst_n = 1'b1;
    check("t6_valid", 32'(bus.o_valid), 32'h0);
    check("t6_value", bus.o_value, 32'h0);
    for (int d = 5; d < ND; d++) show(d, PAT[d], SC, 1'b1);
    idle(1'b1); idle(1'b1);
    check("t6_partial", 32'(bus.o_valid), 32'h0);
    for (int d = 0; d < 5; d++) show(d, PAT[d], SC, 1'b1);
    idle(1'b1);
    check("t6_frame", bus.o_value, 32'h76543210);

    // Randomized runs with random strobe, back-pressure and occasional reset.
    for (int g = 0; g < 1200; g++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      seg = PAT[$urandom_range(0, 15)];
      else if (r < 80) seg = DASH;
      else if (r < 85) seg = BLANK;
      else             seg = 7'($urandom);
      sel = ND'(1) << $urandom_range(0, ND - 1);
      if ($urandom_range(0, 19) == 0) sel = ND'($urandom);
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++)
        cyc(($urandom_range(0, 4) != 0), sel, seg, ($urandom_range(0, 9) < 6));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_hex_capture.md
# seg_hex_capture

Reads back a multiplexed, active-low seven-segment display bus (one digit selected at a time) and reconstructs the hexadecimal value being shown. It sits beside the board display drivers, on the debug/self-check path. Its job is to confirm that what the HEX displays show matches the core's I/O register contents. The block filters glitches by requiring a stable pattern, decodes each digit back to a nibble, and delivers one complete multi-digit frame at a time through a valid/ready handshake.

## Interface
Parameters:
- NUM_DIGITS, 8: number of multiplexed digits; legal 1..8.
- STABLE_CNT, 4: consecutive identical samples required to commit a digit; legal 1..15.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_sample_en  in  1  sample strobe; bus is sampled only in cycles where this is 1.
- i_digit_sel  in  NUM_DIGITS  one-hot digit select, active-high; bit d = digit d.
- i_seg  in  7  segment lines {g,f,e,d,c,b,a}, active-low.
- o_valid  out  1  frame available.
- i_ready  in  1  consumer accepts frame when o_valid && i_ready.
- o_value  out  4*NUM_DIGITS  decoded frame; digit d in bits [4d+3:4d].
- o_error  out  NUM_DIGITS  bit d set = digit d held an illegal pattern.

## Operation
- Decode table (active-low):
  - 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - A–F: 0100000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Any other pattern is illegal: nibble 4'h0, error bit 1.
- Tracker registers: last_sel, last_seg, cnt (4 bits).
- On each i_sample_en=1 cycle:
  - i_digit_sel not one-hot (zero or multiple bits): sample ignored, cnt cleared.
  - Same sel and seg as last_sel/last_seg: cnt increments, saturating at STABLE_CNT.
  - Otherwise: last_sel and last_seg are loaded, cnt=1.
- Commit happens in the cycle cnt reaches STABLE_CNT, once per stable run; saturated repeats do not re-commit. With STABLE_CNT=1, every valid sample commits.
- Commit writes the decoded nibble into acc[d] and the illegal flag into err[d], and sets seen[d]. Re-commits to a digit overwrite it (latest wins).
- State machine:
  - COLLECT: seen != all-ones. Go to PENDING in the cycle after a commit completes seen.
  - PENDING: if the output slot is free (!o_valid, or o_valid && i_ready this cycle), copy acc→o_value and err→o_error, set o_valid=1, clear seen, go to COLLECT. Otherwise stay. Commits in PENDING still update acc/err.
- Output handshake: o_valid holds until accepted. o_value and o_error are stable while o_valid && !i_ready. Acceptance with no pending frame clears o_valid.

## Timing
- Reset values: o_valid=0, o_value=0, o_error=0, seen=0, acc=0, err=0, cnt=0, last_sel=0, last_seg=7'h7F, state COLLECT.
- Reset mid-run discards any partial frame and any held output frame.
- Latency: the commit completing a frame lands at edge T. o_valid=1 after edge T+1 if the slot is free.
- Back-to-back: acceptance and a new transfer can occur in the same cycle. Throughput is one frame per cycle at the handshake.
- A commit and a PENDING transfer in the same cycle: the transfer copies the pre-commit acc. The commit sets seen for the next frame.
- i_sample_en=0 cycles leave the tracker unchanged. Stability is counted in samples, not clocks.

## Configuration
- SEGCAP_DASH_OK_EN defined: dash pattern 0111111 is legal, decodes to nibble 4'h0 with error bit 0.
- Not defined: dash is illegal, like any other undefined pattern (nibble 4'h0, error bit 1).
- Blank 1111111 is illegal in both builds.

## Test plan
- STABLE_CNT=4, NUM_DIGITS=8, i_ready=1, each digit d shows nibble d for 4 samples → one frame: o_value=32'h76543210, o_error=8'h00, o_valid for 1 cycle.
- Digit 2 toggles 0100100/0110000 every sample for 10 samples, then holds 0110000 for 4 → digit 2 commits once as 4'h3; no earlier commit.
- i_digit_sel=8'b00000011 for 6 samples with a fixed pattern → no commit, cnt=0; seen unchanged.
- Full frame with i_ready=0 for 20 cycles, digit 0 then re-committed as 4'hF → o_value frozen until accept; next frame carries digit 0 = 4'hF.
- Digit 5 shows 0111111 → without SEGCAP_DASH_OK_EN: o_error[5]=1, nibble 0; with it: o_error[5]=0, nibble 0.
- Assert i_rst_n=0 after 5 of 8 digits committed → all outputs 0; the next frame requires all 8 digits again.
